// File: rtl/int_divider_58x34.sv
// Sequential radix-2 restoring divider: 58-bit dividend / 34-bit divisor -> 24-bit quotient, 34-bit remainder.
// One division in flight; valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready high)
// RUN   | one restoring iteration per clock, quotient bit MSB first
// DONE  | result held on outputs until out_ready
module int_divider_58x34 #(
    parameter int DIVIDEND_W = 58,
    parameter int DIVISOR_W  = 34,
    parameter int QUOT_W     = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  overflow,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(QUOT_W);

    generate
        if (QUOT_W != DIVIDEND_W - DIVISOR_W) begin : g_bad_width
            $error("int_divider_58x34: QUOT_W must equal DIVIDEND_W - DIVISOR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DIVISOR_W-1:0]   divisor_q, divisor_d;
    logic [DIVISOR_W-1:0]   rem_q, rem_d;
    // Holds the unconsumed low dividend bits during RUN; quotient bits shift in from the LSB.
    logic [QUOT_W-1:0]      quot_q, quot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   dbz_q, dbz_d;

    logic                   accept;
    logic [DIVISOR_W-1:0]   dvd_hi;
    logic [DIVISOR_W:0]     trial;
    logic [DIVISOR_W:0]     diff;
    logic                   trial_ge;

    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign dvd_hi    = dividend[DIVIDEND_W-1:QUOT_W];
    assign trial     = {rem_q, quot_q[QUOT_W-1]};
    assign diff      = trial - {1'b0, divisor_q};
    assign trial_ge  = (trial >= {1'b0, divisor_q});

    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    divisor_d = divisor;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else if (dvd_hi >= divisor) begin
                        // Quotient would need more than QUOT_W bits.
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        rem_d   = dvd_hi;
                        quot_d  = dividend[QUOT_W-1:0];
                        cnt_d   = CNT_W'(QUOT_W - 1);
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (trial_ge) begin
                    rem_d  = diff[DIVISOR_W-1:0];
                    quot_d = {quot_q[QUOT_W-2:0], 1'b1};
                end else begin
                    rem_d  = trial[DIVISOR_W-1:0];
                    quot_d = {quot_q[QUOT_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_int_divider_58x34.sv
// Self-checking bench for int_divider_58x34: directed cases plus randomized operands
// checked against a plain-arithmetic reference (/ and %).
module tb_int_divider_58x34;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [57:0] dividend;
    logic [33:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] quotient;
    logic [33:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    int passed = 0;
    int total  = 0;

    logic [57:0] cur_a;
    logic [33:0] cur_b;

    int_divider_58x34 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: quotient/remainder from ordinary integer division.
    // Latency is counted in clock edges after the accept edge until out_valid is seen.
    task automatic model(input logic [57:0] a, input logic [33:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic ovf, output logic dbz, output int lat);
        longint unsigned la, lb, qf;
        la = 64'(a);
        lb = 64'(b);
        ovf = 1'b0;
        dbz = 1'b0;
        if (lb == 0) begin
            dbz = 1'b1; q = 64'hFF_FFFF; r = 0; lat = 0;
        end else begin
            qf = la / lb;
            if (qf > 64'hFF_FFFF) begin
                ovf = 1'b1; q = 64'hFF_FFFF; r = 0; lat = 0;
            end else begin
                q = qf; r = la % lb; lat = 24;
            end
        end
    endtask

    task automatic send(input logic [57:0] a, input logic [33:0] b);
        int n;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cur_a = a;
        cur_b = b;
    endtask

    task automatic collect(input string tag);
        logic [63:0] q, r;
        logic ovf, dbz;
        int lat, exp_lat;
        model(cur_a, cur_b, q, r, ovf, dbz, exp_lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_q"},   64'(quotient), q);
        check({tag, "_r"},   64'(remainder), r);
        check({tag, "_ovf"}, 64'(overflow), 64'(ovf));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(dbz));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, 64'(out_valid), 64'd0);
        check({tag, "_rdy"},    64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] rq, rb, rr, tmp;
        logic        any_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_q",         64'(quotient), 64'd0);
        check("rst_r",         64'(remainder), 64'd0);
        check("rst_flags",     64'({overflow, div_by_zero}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Round trip of a 24x34 product.
        send(58'(64'hABCDEF * 64'h3_FFFF_FFFF), 34'h3_FFFF_FFFF);
        collect("roundtrip");
        handshake("roundtrip");

        send(58'd100, 34'd7);   collect("small");  handshake("small");
        send(58'd0,   34'd5);   collect("zero");   handshake("zero");
        send(58'h123, 34'd0);   collect("dbz");    handshake("dbz");
        send(58'hFF_FFFF, 34'd1);  collect("max_fit");  handshake("max_fit");
        send(58'h100_0000, 34'd1); collect("ovf_edge"); handshake("ovf_edge");

        // Backpressure: result must hold and new operands must be ignored while DONE.
        send(58'd100, 34'd7);
        collect("bp");
        in_valid = 1'b1;
        dividend = 58'd1000;
        divisor  = 34'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_q",     64'(quotient), 64'd14);
            check("bp_hold_r",     64'(remainder), 64'd2);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        handshake("bp");
        send(58'd1000, 34'd3);
        collect("bp_next");
        handshake("bp_next");

        // Reset mid-RUN aborts the division.
        send(58'h2_3456_789A_BCDE, 34'h1_2345_6789);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready), 64'd0);
        check("abort_q",         64'(quotient), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            any_valid = any_valid | out_valid;
        end
        check("abort_no_result", 64'(any_valid), 64'd0);
        send(58'd1000, 34'd3);
        collect("post_abort");
        handshake("post_abort");

        // Randomized: mostly in-range operands built as q*b+r, some raw (overflow) and zero divisors.
        for (int k = 0; k < 40; k++) begin
            tmp = {$urandom(), $urandom()};
            rb  = 64'(tmp[33:0]);
            if (k % 8 == 3) rb = 64'd0;
            else if (k % 4 == 1) rb = 64'(tmp[9:0]) + 64'd1;
            else if (rb == 0) rb = 64'd1;
            if (k % 5 == 4 || rb == 0) begin
                tmp = {$urandom(), $urandom()};
                send(tmp[57:0], rb[33:0]);
            end else begin
                rq  = 64'($urandom() & 32'h00FF_FFFF);
                tmp = {$urandom(), $urandom()};
                rr  = tmp % rb;
                tmp = rq * rb + rr;
                send(tmp[57:0], rb[33:0]);
            end
            collect("rand");
            handshake("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
